// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: write-back, read and scoreboard
// signals of the ID/WB register file.
interface reg_file_wb_if #(
  parameter int W = 32
);
  logic         WE;
  logic [4:0]   WA;
  logic [W-1:0] WD;
  logic [4:0]   RA;
  logic [4:0]   RB;
  logic [W-1:0] DA;
  logic [W-1:0] DB;
  logic         ISS;
  logic [4:0]   IREG;
  logic         BUSYA;
  logic         BUSYB;
  logic [31:0]  BUSYV;

  modport master (
    output WE, WA, WD, RA, RB, ISS, IREG,
    input  DA, DB, BUSYA, BUSYB, BUSYV
  );

  modport slave (
    input  WE, WA, WD, RA, RB, ISS, IREG,
    output DA, DB, BUSYA, BUSYB, BUSYV
  );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32x32 register file with write-through
// bypass reads and a per-register busy scoreboard.
module reg_file_wb #(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input logic          clk,
  input logic          reset,
  reg_file_wb_if.slave bus
);
  logic [W-1:0]    rf [NREG];
  logic [NREG-1:0] we_dec;
  logic [NREG-1:0] set_dec;
  logic [NREG-1:0] busy;
  logic            hit_a;
  logic            hit_b;

  // One-hot write and issue decodes; r0 never enabled
  always_comb begin
    we_dec  = '0;
    set_dec = '0;
    if (bus.WE) we_dec[bus.WA] = 1'b1;
    if (bus.ISS) set_dec[bus.IREG] = 1'b1;
    we_dec[0]  = 1'b0;
    set_dec[0] = 1'b0;
  end

  // Register storage; r0 stays at its reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (we_dec[i]) rf[i] <= bus.WD;
    end
  end

  // Scoreboard: a new issue outranks the retiring write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~we_dec) | set_dec;
  end

  // Bypassed reads and busy masks
  always_comb begin
    hit_a = bus.WE && (bus.WA == bus.RA);
    hit_b = bus.WE && (bus.WA == bus.RB);
    if (reset || bus.RA == 5'd0) bus.DA = '0;
    else if (hit_a)              bus.DA = bus.WD;
    else                         bus.DA = rf[bus.RA];
    if (reset || bus.RB == 5'd0) bus.DB = '0;
    else if (hit_b)              bus.DB = bus.WD;
    else                         bus.DB = rf[bus.RB];
    bus.BUSYA = busy[bus.RA] && !hit_a;
    bus.BUSYB = busy[bus.RB] && !hit_b;
    bus.BUSYV = busy;
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed checks of reg_file_wb.
// Inputs change 1ns after posedge; checks follow 1ns later.
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_wb_if #(.W(32)) bus ();

  reg_file_wb #(.NREG(32), .W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    bus.WE = 0; bus.WA = 0; bus.WD = 0;
    bus.RA = 0; bus.RB = 0;
    bus.ISS = 0; bus.IREG = 0;
    #1;
    check("rst_da", bus.DA, 32'h0);
    check("rst_busyv", bus.BUSYV, 32'h0);
    tick();
    reset = 0;
    // write r5, issue r3 on the same edge
    bus.WE = 1; bus.WA = 5; bus.WD = 32'hDEADBEEF;
    bus.ISS = 1; bus.IREG = 3;
    tick();
    bus.WE = 0; bus.ISS = 0; bus.RA = 5;
    #1;
    check("wr_r5", bus.DA, 32'hDEADBEEF);
    check("busy_r3", bus.BUSYV, 32'h0000_0008);
    // async reset between edges
    reset = 1;
    #1;
    check("async_da", bus.DA, 32'h0);
    check("async_busyv", bus.BUSYV, 32'h0);
    // reset overrides a coincident write/issue
    bus.WE = 1; bus.WA = 6; bus.WD = 32'hAA;
    bus.ISS = 1; bus.IREG = 6; bus.RA = 6;
    check("rst_bypass", bus.DA, 32'h0);
    tick();
    reset = 0; bus.WE = 0; bus.ISS = 0;
    #1;
    check("rst_ovr_r6", bus.DA, 32'h0);
    check("rst_ovr_bv", bus.BUSYV, 32'h0);
    bus.RA = 5;
    #1;
    check("rst_r5", bus.DA, 32'h0);
    tick();
    // bypass then stored value
    bus.WE = 1; bus.WA = 7; bus.WD = 32'h12345678;
    bus.RA = 7;
    #1;
    check("byp_r7", bus.DA, 32'h12345678);
    tick();
    bus.WE = 0;
    #1;
    check("held_r7", bus.DA, 32'h12345678);
    // r0 write discarded
    bus.WE = 1; bus.WA = 0; bus.WD = 32'hFFFFFFFF;
    bus.RA = 0; bus.RB = 0;
    #1;
    check("r0_byp_a", bus.DA, 32'h0);
    check("r0_byp_b", bus.DB, 32'h0);
    tick();
    bus.WE = 0;
    #1;
    check("r0_a", bus.DA, 32'h0);
    check("r0_b", bus.DB, 32'h0);
    // scoreboard set then clear
    bus.ISS = 1; bus.IREG = 9;
    tick();
    bus.ISS = 0; bus.RA = 9; bus.RB = 9;
    #1;
    check("bv9_set", bus.BUSYV, 32'h0000_0200);
    check("busya9", {31'b0, bus.BUSYA}, 32'h1);
    check("busyb9", {31'b0, bus.BUSYB}, 32'h1);
    bus.WE = 1; bus.WA = 9; bus.WD = 32'h99;
    #1;
    check("busya9_mask", {31'b0, bus.BUSYA}, 32'h0);
    check("bv9_unmask", bus.BUSYV, 32'h0000_0200);
    check("byp_r9", bus.DA, 32'h99);
    tick();
    bus.WE = 0;
    #1;
    check("bv9_clr", bus.BUSYV, 32'h0);
    // set wins over clear on the same register
    bus.ISS = 1; bus.IREG = 4;
    tick();
    bus.WE = 1; bus.WA = 4; bus.WD = 32'h44;
    tick();
    bus.WE = 0; bus.ISS = 0; bus.RA = 4; bus.RB = 4;
    #1;
    check("setwin_bv", bus.BUSYV, 32'h0000_0010);
    check("setwin_r4", bus.DA, 32'h44);
    check("setwin_bb", {31'b0, bus.BUSYB}, 32'h1);
    // set and clear on different registers
    bus.ISS = 1; bus.IREG = 10;
    bus.WE = 1; bus.WA = 4; bus.WD = 32'h4444;
    tick();
    bus.WE = 0; bus.ISS = 0;
    #1;
    check("split_bv", bus.BUSYV, 32'h0000_0400);
    // issue to r0 ignored; re-issue keeps busy
    bus.ISS = 1; bus.IREG = 0;
    tick();
    bus.IREG = 10;
    tick();
    bus.ISS = 0;
    #1;
    check("iss_r0", bus.BUSYV, 32'h0000_0400);
    // X on idle address lines changes nothing
    bus.WA = 'x; bus.IREG = 'x; bus.WD = 'x;
    tick();
    bus.WA = 0; bus.IREG = 0; bus.WD = 0; bus.RA = 7;
    #1;
    check("x_bv", bus.BUSYV, 32'h0000_0400);
    check("x_r7", bus.DA, 32'h12345678);
    bus.WE = 1; bus.WA = 10; bus.WD = 32'h0;
    tick();
    bus.WE = 0;
    #1;
    check("clr_r10", bus.BUSYV, 32'h0);
    // sweep of all write enables
    for (int i = 1; i < 32; i++) begin
      bus.WE = 1; bus.WA = 5'(i);
      bus.WD = i * 32'h01010101;
      tick();
    end
    bus.WE = 0;
    for (int i = 0; i < 32; i++) begin
      bus.RA = 5'(i); bus.RB = 5'(31 - i);
      #1;
      e = i * 32'h01010101;
      check($sformatf("sweep_a%0d", i), bus.DA, e);
      e = (31 - i) * 32'h01010101;
      check($sformatf("sweep_b%0d", i), bus.DB, e);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
